// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller: FSM state
// encoding and the memory rw encoding.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        CAP  = 2'd2,
        WR   = 2'd3
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mdr_bus_driver.sv
// Tristate driver and read-capture register for the shared MDR bus.
// Upper capture word exists only when MEM_ACCESS_DWORD_EN is defined.
module mdr_bus_driver #(
    parameter int WORD_LENGTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     drive_en,
    input  logic [WORD_LENGTH-1:0]   wdata,
    input  logic                     capture_en,
    input  logic                     capture_hi,
    output logic [2*WORD_LENGTH-1:0] rdata,
    inout  wire  [WORD_LENGTH-1:0]   MDR
);

    logic [2*WORD_LENGTH-1:0] rdata_r;

    assign MDR   = drive_en ? wdata : {WORD_LENGTH{1'bz}};
    assign rdata = rdata_r;

`ifndef MEM_ACCESS_DWORD_EN
    logic unused_s;
    assign unused_s = capture_hi;
`endif

    // Capture the word the memory drives during CAP into the selected half.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= {(2*WORD_LENGTH){1'b0}};
        end else if (capture_en) begin
`ifdef MEM_ACCESS_DWORD_EN
            if (capture_hi) begin
                rdata_r[2*WORD_LENGTH-1:WORD_LENGTH] <= MDR;
            end else begin
                rdata_r[WORD_LENGTH-1:0] <= MDR;
            end
`else
            rdata_r <= {{WORD_LENGTH{1'b0}}, MDR};
`endif
        end else begin
            rdata_r <= rdata_r;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator sequencing MAR/MDR/mem/rw/en toward a synchronous data
// memory. MEM_ACCESS_DWORD_EN enables two-beat (double-word) accesses.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WORD_LENGTH   = 16,
    parameter int ADDRESS_SPACE = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_rw,
    input  logic                     req_dword,
    input  logic [ADDRESS_SPACE-1:0] req_addr,
    input  logic [2*WORD_LENGTH-1:0] req_wdata,
    output logic                     rsp_valid,
    output logic [2*WORD_LENGTH-1:0] rsp_rdata,
    output logic                     stall,
    output logic [ADDRESS_SPACE-1:0] MAR,
    inout  wire  [WORD_LENGTH-1:0]   MDR,
    output logic                     mem,
    output logic                     rw,
    output logic                     en
);

    localparam logic [ADDRESS_SPACE-1:0] ADDR_ONE = {{(ADDRESS_SPACE-1){1'b0}}, 1'b1};

    state_t                   state_r;
    logic                     beat_r;
    logic                     dword_r;
    logic [ADDRESS_SPACE-1:0] addr_r;
    logic [2*WORD_LENGTH-1:0] wdata_r;
    logic                     req_ready_r;
    logic                     rsp_valid_r;
    logic                     mem_r;
    logic                     en_r;
    logic                     rw_r;
    logic [ADDRESS_SPACE-1:0] mar_r;
    logic                     drive_r;
    logic [WORD_LENGTH-1:0]   wword_r;
    logic                     dword_req_s;
    logic                     capture_s;

`ifdef MEM_ACCESS_DWORD_EN
    assign dword_req_s = req_dword;
`else
    logic unused_s;
    assign dword_req_s = 1'b0;
    assign unused_s    = req_dword;
`endif

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign stall     = (state_r != IDLE);
    assign MAR       = mar_r;
    assign mem       = mem_r;
    assign rw        = rw_r;
    assign en        = en_r;
    assign capture_s = (state_r == CAP);

    // Access sequencer; bus controls are registered one step ahead of the state they belong to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            beat_r      <= 1'b0;
            dword_r     <= 1'b0;
            addr_r      <= {ADDRESS_SPACE{1'b0}};
            wdata_r     <= {(2*WORD_LENGTH){1'b0}};
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            mem_r       <= 1'b0;
            en_r        <= 1'b0;
            rw_r        <= RW_READ;
            mar_r       <= {ADDRESS_SPACE{1'b0}};
            drive_r     <= 1'b0;
            wword_r     <= {WORD_LENGTH{1'b0}};
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        dword_r     <= dword_req_s;
                        beat_r      <= 1'b0;
                        req_ready_r <= 1'b0;
                        mar_r       <= req_addr;
                        mem_r       <= 1'b1;
                        en_r        <= 1'b1;
                        if (req_rw == RW_READ) begin
                            state_r <= RD;
                            rw_r    <= RW_READ;
                            drive_r <= 1'b0;
                        end else begin
                            state_r <= WR;
                            rw_r    <= RW_WRITE;
                            drive_r <= 1'b1;
                            wword_r <= req_wdata[WORD_LENGTH-1:0];
                        end
                    end else begin
                        mem_r   <= 1'b0;
                        en_r    <= 1'b0;
                        drive_r <= 1'b0;
                    end
                end
                RD: begin
                    state_r <= CAP;
                    mem_r   <= 1'b0;
                    en_r    <= 1'b1;
                    rw_r    <= RW_READ;
                    drive_r <= 1'b0;
                end
                CAP: begin
                    if (dword_r && !beat_r) begin
                        state_r <= RD;
                        beat_r  <= 1'b1;
                        mem_r   <= 1'b1;
                        mar_r   <= addr_r + ADDR_ONE;
                    end else begin
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b1;
                        req_ready_r <= 1'b1;
                        mem_r       <= 1'b0;
                        en_r        <= 1'b0;
                    end
                end
                WR: begin
                    if (dword_r && !beat_r) begin
                        beat_r  <= 1'b1;
                        mar_r   <= addr_r + ADDR_ONE;
                        wword_r <= wdata_r[2*WORD_LENGTH-1:WORD_LENGTH];
                        drive_r <= 1'b1;
                    end else begin
                        // rw returns to read so the idle bus never looks like a write
                        state_r     <= IDLE;
                        rsp_valid_r <= 1'b1;
                        req_ready_r <= 1'b1;
                        mem_r       <= 1'b0;
                        en_r        <= 1'b0;
                        rw_r        <= RW_READ;
                        drive_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                    mem_r       <= 1'b0;
                    en_r        <= 1'b0;
                    rw_r        <= RW_READ;
                    drive_r     <= 1'b0;
                end
            endcase
        end
    end

    mdr_bus_driver #(
        .WORD_LENGTH(WORD_LENGTH)
    ) u_mdr (
        .clk        (clk),
        .reset      (reset),
        .drive_en   (drive_r),
        .wdata      (wword_r),
        .capture_en (capture_s),
        .capture_hi (beat_r),
        .rdata      (rsp_rdata),
        .MDR        (MDR)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench: synchronous memory model on MDR, word-array reference
// model, directed cases then randomized traffic.
module tb_mem_access_ctrl;

`ifdef MEM_ACCESS_DWORD_EN
    localparam bit DW_ON = 1'b1;
`else
    localparam bit DW_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rw = 1'b1;
    logic        req_dword = 1'b0;
    logic [11:0] req_addr = 12'h000;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        stall;
    logic [11:0] MAR;
    wire  [15:0] MDR;
    logic        mem;
    logic        rw;
    logic        en;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mem_arr [4096];
    logic [15:0] ref_mem [4096];
    logic        init_mem = 1'b1;
    logic        mem_drive_r = 1'b0;
    logic [15:0] mem_q_r = 16'h0;
    logic [31:0] exp_rdata = 32'h0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_dword(req_dword), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .stall(stall), .MAR(MAR), .MDR(MDR), .mem(mem), .rw(rw), .en(en)
    );

    function automatic logic [15:0] pattern(input int i);
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    // Synchronous memory: write on strobe with rw=0, read data driven the following cycle.
    assign MDR = mem_drive_r ? mem_q_r : 16'bz;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 4096; i++) mem_arr[i] <= pattern(i);
            mem_drive_r <= 1'b0;
        end else begin
            if (mem && en && !rw) mem_arr[MAR] <= MDR;
            if (mem && en && rw) begin
                mem_q_r     <= mem_arr[MAR];
                mem_drive_r <= 1'b1;
            end else begin
                mem_drive_r <= 1'b0;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Bus contention watch: memory must never drive while the block is writing.
    always @(negedge clk) begin
        if (mem_drive_r && !reset) check_eq("mdr_contention", {31'h0, mem && !rw}, 32'h0);
    end

    // Issue one request at a negedge and wait for its response; model updated from the rules.
    task automatic issue(input logic r, input logic dw, input logic [11:0] a, input logic [31:0] wd);
        int n;
        int lat;
        logic eff;
        logic [11:0] a1;
        eff = dw && DW_ON;
        a1  = a + 12'h001;
        lat = r ? (eff ? 5 : 3) : (eff ? 3 : 2);
        if (r) begin
            exp_rdata[15:0] = ref_mem[a];
            if (eff) exp_rdata[31:16] = ref_mem[a1];
        end else begin
            ref_mem[a] = wd[15:0];
            if (eff) ref_mem[a1] = wd[31:16];
        end
        check_eq("req_ready_idle", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_rw = r; req_dword = dw; req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_wdata = $urandom;
        n = 1;
        while (!rsp_valid && n < 20) begin
            check_eq("stall_busy", {31'h0, stall}, 32'h1);
            @(negedge clk);
            n++;
        end
        check_eq(r ? "read_latency" : "write_latency", 32'(n), 32'(lat));
        check_eq(r ? "read_rdata" : "held_rdata", rsp_rdata, exp_rdata);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = pattern(i);
        repeat (2) @(negedge clk);
        init_mem = 1'b0;
        reset    = 1'b0;
        @(negedge clk);
        check_eq("rst_mem", {31'h0, mem}, 32'h0);
        check_eq("rst_en", {31'h0, en}, 32'h0);
        check_eq("rst_rw", {31'h0, rw}, 32'h1);
        check_eq("rst_mar", {20'h0, MAR}, 32'h0);
        check_eq("rst_ready", {31'h0, req_ready}, 32'h1);
        check_eq("rst_stall", {31'h0, stall}, 32'h0);
        check_eq("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_eq("rst_rdata", rsp_rdata, 32'h0);

        issue(1'b0, 1'b0, 12'h010, 32'h0000_BEEF);
        issue(1'b1, 1'b0, 12'h010, 32'h0);
        check_eq("beef_readback", {16'h0, rsp_rdata[15:0]}, 32'h0000_BEEF);

        issue(1'b1, 1'b0, 12'h020, 32'h0);
        issue(1'b0, 1'b0, 12'h021, 32'h0000_1234);
        issue(1'b1, 1'b0, 12'h021, 32'h0);
        check_eq("b2b_readback", {16'h0, rsp_rdata[15:0]}, 32'h0000_1234);

        issue(1'b0, 1'b1, 12'hFFF, 32'hCAFE_0001);
        issue(1'b1, 1'b1, 12'hFFF, 32'h0);
        issue(1'b1, 1'b1, 12'h030, 32'h0);
        if (!DW_ON) check_eq("nodw_upper_zero", {16'h0, rsp_rdata[31:16]}, 32'h0);

        // Reset during the CAP cycle of a single read.
        req_valid = 1'b1; req_rw = 1'b1; req_dword = 1'b0; req_addr = 12'h040;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_rdata = 32'h0;
        check_eq("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check_eq("midrst_stall", {31'h0, stall}, 32'h0);
        check_eq("midrst_ready", {31'h0, req_ready}, 32'h1);
        check_eq("midrst_mem_en", {30'h0, mem, en}, 32'h0);
        check_eq("midrst_rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        check_eq("midrst_no_late_rsp", {31'h0, rsp_valid}, 32'h0);

        for (int k = 0; k < 60; k++) begin
            logic [11:0] a;
            a = ($urandom_range(0, 3) == 0) ? 12'hFFF : 12'($urandom_range(0, 63));
            issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
